// File: rtl/pll_rst_pkg.sv
// -----------------------------------------------------------------------------
// pll_rst_pkg
// Shared definitions for the PLL reset sequencer:
//   - pll_rst_state_e : sequencer FSM state encoding
//   - default timing constants used as parameter defaults by the sequencer
//   - max_int()       : helper used to size the shared cycle counter
// -----------------------------------------------------------------------------
package pll_rst_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } pll_rst_state_e;

    localparam int PLL_SYNC_STAGES        = 2;
    localparam int PLL_LOCK_STABLE_CYCLES = 1024;
    localparam int PLL_HOLD_CYCLES        = 16;
    localparam int PLL_LOSS_CNT_W         = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// -----------------------------------------------------------------------------
// bit_sync
// N-flop single-bit synchronizer for an asynchronous input. All flops reset
// asynchronously to 0.
// Ports:
//   clk_i   : destination clock
//   rst_n_i : asynchronous active-low reset
//   d_i     : asynchronous input bit
//   q_o     : synchronized output (last flop of the chain)
// -----------------------------------------------------------------------------
module bit_sync #(
    parameter int N = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic [N-1:0] sync_q;
    logic [N-1:0] sync_d;

    // Stage 0 captures the raw input, every later stage takes its predecessor.
    for (genvar gi = 0; gi < N; gi++) begin : g_stage
        if (gi == 0) begin : g_first
            assign sync_d[gi] = d_i;
        end else begin : g_rest
            assign sync_d[gi] = sync_q[gi-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[N-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
// Generates a clean system reset from the PLL lock indication. Reset is
// released only after lock has been stable for LOCK_STABLE_CYCLES plus a
// HOLD_CYCLES hold period; a lock loss while running re-asserts reset and is
// recorded in a sticky flag and a saturating counter.
// Ports:
//   clk_i             : PLL output clock
//   rst_n_i           : asynchronous active-low reset
//   pll_locked_i      : PLL lock, asynchronous to clk_i
//   sw_reset_req_i    : single-cycle soft-reset request (acted on only in RUN)
//   clear_status_i    : single-cycle pulse clearing lock_lost_o
//   sys_rst_n_o       : registered active-low system reset
//   ready_o           : high while in RUN
//   lock_lost_o       : sticky, lock dropped while in RUN
//   lock_loss_count_o : saturating count of lock losses in RUN
// -----------------------------------------------------------------------------
module pll_reset_sequencer
    import pll_rst_pkg::*;
#(
    parameter int SYNC_STAGES        = PLL_SYNC_STAGES,
    parameter int LOCK_STABLE_CYCLES = PLL_LOCK_STABLE_CYCLES,
    parameter int HOLD_CYCLES        = PLL_HOLD_CYCLES,
    parameter int LOSS_CNT_W         = PLL_LOSS_CNT_W
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  pll_locked_i,
    input  logic                  sw_reset_req_i,
    input  logic                  clear_status_i,
    output logic                  sys_rst_n_o,
    output logic                  ready_o,
    output logic                  lock_lost_o,
    output logic [LOSS_CNT_W-1:0] lock_loss_count_o
);

    localparam int CNT_W = $clog2(max_int(LOCK_STABLE_CYCLES, HOLD_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

    logic locked_s;

    pll_rst_state_e        state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  sys_rst_n_q, sys_rst_n_d;
    logic                  ready_q, ready_d;
    logic                  lock_lost_q, lock_lost_d;
    logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;
    logic                  loss_event;

    bit_sync #(
        .N (SYNC_STAGES)
    ) u_lock_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (pll_locked_i),
        .q_o     (locked_s)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        loss_event = 1'b0;

        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (locked_s) begin
                    state_d = STABLE;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                cnt_d = '0;
                // Lock loss outranks a soft reset arriving in the same cycle.
                if (!locked_s) begin
                    state_d    = WAIT_LOCK;
                    loss_event = 1'b1;
                end else if (sw_reset_req_i) begin
                    // Lock is already proven, so skip straight to the hold.
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered from the next state so reset edges line up
        // with the state entering / leaving RUN.
        sys_rst_n_d = (state_d == RUN);
        ready_d     = (state_d == RUN);

        // A new loss wins over a clear in the same cycle.
        if (loss_event) begin
            lock_lost_d = 1'b1;
        end else if (clear_status_i) begin
            lock_lost_d = 1'b0;
        end else begin
            lock_lost_d = lock_lost_q;
        end

        if (loss_event && (loss_cnt_q != '1)) begin
            loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
        end else begin
            loss_cnt_d = loss_cnt_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
            loss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sys_rst_n_q <= sys_rst_n_d;
            ready_q     <= ready_d;
            lock_lost_q <= lock_lost_d;
            loss_cnt_q  <= loss_cnt_d;
        end
    end

    assign sys_rst_n_o       = sys_rst_n_q;
    assign ready_o           = ready_q;
    assign lock_lost_o       = lock_lost_q;
    assign lock_loss_count_o = loss_cnt_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_sequencer
// Directed bench for pll_reset_sequencer with SYNC_STAGES=2,
// LOCK_STABLE_CYCLES=8, HOLD_CYCLES=4, LOSS_CNT_W=8.
// Edges are numbered from 1 = first edge that samples pll_locked high, so
// sys_rst_n must rise on edge 15 (2 + 1 + 8 + 4).
// -----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

    localparam int LOCK_EDGES = 15;

    logic       clk;
    logic       rst_n;
    logic       pll_locked;
    logic       sw_reset_req;
    logic       clear_status;
    logic       sys_rst_n;
    logic       ready;
    logic       lock_lost;
    logic [7:0] lock_loss_count;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_cnt;

    typedef struct packed {
        logic       lk;
        logic       sw;
        logic       clr;
        logic       sys;
        logic       rdy;
        logic       ll;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs [11];

    pll_reset_sequencer #(
        .SYNC_STAGES        (2),
        .LOCK_STABLE_CYCLES (8),
        .HOLD_CYCLES        (4),
        .LOSS_CNT_W         (8)
    ) dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .pll_locked_i      (pll_locked),
        .sw_reset_req_i    (sw_reset_req),
        .clear_status_i    (clear_status),
        .sys_rst_n_o       (sys_rst_n),
        .ready_o           (ready),
        .lock_lost_o       (lock_lost),
        .lock_loss_count_o (lock_loss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string name, input logic s, input logic r,
                           input logic l, input logic [7:0] c);
        chk({name, "_sys_rst_n"}, 32'(sys_rst_n), 32'(s));
        chk({name, "_ready"}, 32'(ready), 32'(r));
        chk({name, "_lock_lost"}, 32'(lock_lost), 32'(l));
        chk({name, "_count"}, 32'(lock_loss_count), 32'(c));
    endtask

    // Clock through the rest of a lock-up sequence; 'done' edges have already
    // sampled pll_locked high. Reset must stay low until exactly edge 15.
    task automatic check_lockup(input string name, input int done);
        for (int e = done + 1; e <= LOCK_EDGES; e++) begin
            step();
            if (e < LOCK_EDGES) begin
                chk({name, "_early"}, 32'(sys_rst_n), 32'd0);
            end else begin
                chk({name, "_sys_rst_n"}, 32'(sys_rst_n), 32'd1);
                chk({name, "_ready"}, 32'(ready), 32'd1);
            end
        end
        $display("lockup %s: sys_rst_n=%0b ready=%0b lock_lost=%0b count=%0d",
                 name, sys_rst_n, ready, lock_lost, lock_loss_count);
    endtask

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    initial begin
        // Starts in RUN with lock_lost=0, count=0.
        //             lk    sw    clr   sys   rdy   ll    cnt
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}; // soft reset -> HOLD
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0}; // 4 cycles low, back in RUN
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0}; // clear with nothing set
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0}; // lock drops: edge 1
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0}; // edge 2
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1}; // edge 3: reset, loss logged
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1}; // clear; relock edge 1
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1}; // relock edge 2

        rst_n        = 1'b0;
        pll_locked   = 1'b0;
        sw_reset_req = 1'b0;
        clear_status = 1'b0;
        exp_cnt      = 8'd0;

        // Reset state.
        step();
        step();
        chk_all("reset", 1'b0, 1'b0, 1'b0, 8'd0);

        // Initial lock-up.
        rst_n      = 1'b1;
        pll_locked = 1'b1;
        check_lockup("initial", 0);
        chk_all("initial_status", 1'b1, 1'b1, 1'b0, 8'd0);

        // Table: soft reset, lock loss, clear_status.
        for (int i = 0; i < 11; i++) begin
            pll_locked   = vecs[i].lk;
            sw_reset_req = vecs[i].sw;
            clear_status = vecs[i].clr;
            step();
            $display("vec %0d: lk=%0b sw=%0b clr=%0b -> sys_rst_n=%0b ready=%0b lock_lost=%0b count=%0d",
                     i, vecs[i].lk, vecs[i].sw, vecs[i].clr, sys_rst_n, ready, lock_lost, lock_loss_count);
            chk_all($sformatf("vec%0d", i), vecs[i].sys, vecs[i].rdy, vecs[i].ll, vecs[i].cnt);
        end
        sw_reset_req = 1'b0;
        clear_status = 1'b0;
        exp_cnt      = 8'd1;
        check_lockup("relock", 2);
        chk("relock_count", 32'(lock_loss_count), 32'(exp_cnt));

        // Glitch between edges is never sampled: no effect.
        pll_locked = 1'b0;
        #2;
        pll_locked = 1'b1;
        repeat (5) step();
        chk_all("short_glitch", 1'b1, 1'b1, 1'b0, exp_cnt);

        // Simultaneous lock loss + sw_reset_req + clear_status.
        pll_locked = 1'b0;
        step();
        chk("simul_e1", 32'(sys_rst_n), 32'd1);
        step();
        chk("simul_e2", 32'(sys_rst_n), 32'd1);
        sw_reset_req = 1'b1;
        clear_status = 1'b1;
        step();
        sw_reset_req = 1'b0;
        clear_status = 1'b0;
        exp_cnt      = sat_inc(exp_cnt);
        chk_all("simul", 1'b0, 1'b0, 1'b1, exp_cnt);
        step();
        chk("simul_stay_low", 32'(sys_rst_n), 32'd0);

        // Captured glitch during STABLE (cnt=5) restarts from WAIT_LOCK.
        pll_locked = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk("stable_low", 32'(sys_rst_n), 32'd0);
        end
        pll_locked = 1'b0;
        repeat (3) begin
            step();
            chk("glitch_low", 32'(sys_rst_n), 32'd0);
        end
        pll_locked = 1'b1;
        check_lockup("after_glitch", 0);
        chk_all("after_glitch_status", 1'b1, 1'b1, 1'b1, exp_cnt);

        // Async reset mid-HOLD clears everything without a clock edge.
        sw_reset_req = 1'b1;
        step();
        sw_reset_req = 1'b0;
        step();
        chk("hold_low", 32'(sys_rst_n), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", 1'b0, 1'b0, 1'b0, 8'd0);
        $display("async reset mid-HOLD: sys_rst_n=%0b ready=%0b lock_lost=%0b count=%0d",
                 sys_rst_n, ready, lock_lost, lock_loss_count);
        step();
        step();
        rst_n   = 1'b1;
        exp_cnt = 8'd0;
        check_lockup("post_reset", 0);
        chk_all("post_reset_status", 1'b1, 1'b1, 1'b0, 8'd0);

        // 260 lock losses: counter saturates at 255.
        for (int i = 0; i < 260; i++) begin
            pll_locked = 1'b0;
            repeat (3) step();
            exp_cnt = sat_inc(exp_cnt);
            chk("sat_count", 32'(lock_loss_count), 32'(exp_cnt));
            pll_locked = 1'b1;
            repeat (LOCK_EDGES) step();
        end
        $display("saturation: count=%0d lock_lost=%0b sys_rst_n=%0b",
                 lock_loss_count, lock_lost, sys_rst_n);
        chk_all("saturated", 1'b1, 1'b1, 1'b1, 8'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
